// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace packet scheduler.
package trdb_pkg;

    localparam int unsigned BRANCH_COUNT_LEN       = 5;
    localparam int unsigned RESYNC_CNT_LEN_DEFAULT = 16;

    typedef enum logic [1:0] {
        F_OPT_EXT    = 2'h0,
        F_DIFF_DELTA = 2'h1,
        F_ADDR_ONLY  = 2'h2,
        F_SYNC       = 2'h3
    } trdb_format_e;

    typedef enum logic [1:0] {
        SF_START   = 2'h0,
        SF_TRAP    = 2'h1,
        SF_CONTEXT = 2'h2,
        SF_SUPPORT = 2'h3
    } trdb_f_sync_subformat_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'h0,
        S_SUPPORT = 2'h1,
        S_RUN     = 2'h2,
        S_HOLD    = 2'h3
    } trdb_sched_state_e;

    // Pending-event bit positions; a lower index means a higher priority.
    localparam int N_PEND     = 6;
    localparam int P_START    = 0;
    localparam int P_TRAP     = 1;
    localparam int P_CONTEXT  = 2;
    localparam int P_RESYNC   = 3;
    localparam int P_UPDISCON = 4;
    localparam int P_BMFULL   = 5;

    // One-hot of the highest-priority (lowest-index) set bit.
    function automatic logic [N_PEND-1:0] pick_highest(input logic [N_PEND-1:0] pend);
        logic [N_PEND-1:0] res;
        res = '0;
        for (int i = N_PEND - 1; i >= 0; i--) begin
            if (pend[i]) begin
                res    = '0;
                res[i] = 1'b1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/trdb_resync_counter.sv
// Saturating cycle counter that flags when the resync period is reached.
module trdb_resync_counter
    import trdb_pkg::*;
#(
    parameter int unsigned CNT_LEN = RESYNC_CNT_LEN_DEFAULT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               enable_i,
    input  logic [CNT_LEN-1:0] period_i,
    output logic               expire_o
);

    logic [CNT_LEN-1:0] cnt_q;
    logic [CNT_LEN-1:0] cnt_inc;

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_LEN'(1);

    // Fires once, on the cycle the count steps onto the period; a saturated
    // counter that happens to equal the period does not refire.
    assign expire_o = enable_i && !clear_i && (period_i != '0)
                      && (cnt_inc == period_i) && (cnt_q != period_i);

    // Count register: clear wins over increment.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0;
        end else if (enable_i) begin
            cnt_q <= cnt_inc;
        end
    end

endmodule

// File: rtl/trdb_packet_scheduler.sv
// Decides which trace packet to request next and holds it until accepted.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | trace disabled, events ignored
//   S_SUPPORT | F_SYNC/SF_SUPPORT request outstanding after enable
//   S_RUN     | tracing, no request outstanding
//   S_HOLD    | request outstanding, outputs frozen until ready_i
module trdb_packet_scheduler
    import trdb_pkg::*;
#(
    parameter int unsigned RESYNC_CNT_LEN = RESYNC_CNT_LEN_DEFAULT
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        enable_i,
    input  logic                        start_i,
    input  logic                        trap_i,
    input  logic                        thaddr_i,
    input  logic                        context_i,
    input  logic                        updiscon_i,
    input  logic                        bm_full_i,
    input  logic [BRANCH_COUNT_LEN-1:0] branches_i,
    input  logic [RESYNC_CNT_LEN-1:0]   resync_period_i,
    input  logic                        ready_i,
    output logic                        valid_o,
    output trdb_format_e                format_o,
    output trdb_f_sync_subformat_e      subformat_o,
    output logic                        thaddr_o,
    output logic                        branch_map_flush_o,
    output logic                        lost_o,
    output logic                        busy_o
);

    trdb_sched_state_e      state_q, state_d;
    logic                   valid_q, valid_d;
    trdb_format_e           fmt_q, fmt_d;
    trdb_f_sync_subformat_e sub_q, sub_d;
    logic                   thaddr_q, thaddr_d;
    logic                   tpend_q, tpend_d;
    logic [N_PEND-1:0]      served_q, served_d;
    logic [N_PEND-1:0]      pend_q, pend_d;
    logic                   lost_q, lost_d;
    logic                   flush_q, flush_d;

    logic                   hs;
    logic [N_PEND-1:0]      ev, kept, pend_all, sel;
    logic                   rs_expire, rs_clear, rs_enable;

    assign hs        = valid_q && ready_i;
    assign rs_enable = (state_q == S_RUN) || (state_q == S_HOLD);
    assign rs_clear  = (state_q == S_IDLE) || (hs && fmt_q == F_SYNC);

    trdb_resync_counter #(
        .CNT_LEN (RESYNC_CNT_LEN)
    ) u_resync (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clear_i  (rs_clear),
        .enable_i (rs_enable),
        .period_i (resync_period_i),
        .expire_o (rs_expire)
    );

    // Next state, pending bookkeeping and the next registered request.
    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        fmt_d    = fmt_q;
        sub_d    = sub_q;
        thaddr_d = thaddr_q;
        tpend_d  = tpend_q;
        served_d = served_q;
        pend_d   = pend_q;
        lost_d   = lost_q;
        flush_d  = hs && ((fmt_q == F_DIFF_DELTA) ||
                          (fmt_q == F_SYNC && (sub_q == SF_START || sub_q == SF_TRAP)));

        ev             = '0;
        ev[P_START]    = start_i;
        ev[P_TRAP]     = trap_i;
        ev[P_CONTEXT]  = context_i;
        ev[P_RESYNC]   = rs_expire;
        ev[P_UPDISCON] = updiscon_i;
        ev[P_BMFULL]   = bm_full_i;

        // The bit being acknowledged this cycle is free again, so a same-class
        // event arriving now is a fresh pending request rather than a loss.
        kept     = hs ? (pend_q & ~served_q) : pend_q;
        pend_all = kept | ev;
        if (pend_all[P_START]) begin
            pend_all[P_RESYNC] = 1'b0;
        end
        sel = pick_highest(pend_all);

        case (state_q)
            S_IDLE: begin
                if (enable_i) begin
                    state_d  = S_SUPPORT;
                    valid_d  = 1'b1;
                    fmt_d    = F_SYNC;
                    sub_d    = SF_SUPPORT;
                    thaddr_d = 1'b0;
                    served_d = '0;
                end
            end
            S_SUPPORT: begin
                if (hs) begin
                    valid_d = 1'b0;
                    fmt_d   = F_OPT_EXT;
                    sub_d   = SF_START;
                    state_d = enable_i ? S_RUN : S_IDLE;
                end
            end
            S_RUN, S_HOLD: begin
                if (!enable_i) begin
                    pend_d = '0;
                    if (!valid_q || hs) begin
                        state_d  = S_IDLE;
                        valid_d  = 1'b0;
                        fmt_d    = F_OPT_EXT;
                        sub_d    = SF_START;
                        thaddr_d = 1'b0;
                        served_d = '0;
                    end
                end else begin
                    pend_d = pend_all;
                    lost_d = lost_q | (|(ev & kept));
                    if (ev[P_TRAP] && !kept[P_TRAP]) begin
                        tpend_d = thaddr_i;
                    end
                    if (!valid_q || hs) begin
                        if (|pend_all) begin
                            state_d  = S_HOLD;
                            valid_d  = 1'b1;
                            served_d = sel;
                            fmt_d    = F_SYNC;
                            sub_d    = SF_START;
                            thaddr_d = 1'b0;
                            if (sel[P_TRAP]) begin
                                sub_d    = SF_TRAP;
                                thaddr_d = tpend_d;
                            end else if (sel[P_CONTEXT]) begin
                                sub_d = SF_CONTEXT;
                            end else if (sel[P_UPDISCON]) begin
                                fmt_d = (branches_i == '0) ? F_ADDR_ONLY : F_DIFF_DELTA;
                            end else if (sel[P_BMFULL]) begin
                                fmt_d = F_DIFF_DELTA;
                            end
                        end else begin
                            state_d  = S_RUN;
                            valid_d  = 1'b0;
                            fmt_d    = F_OPT_EXT;
                            sub_d    = SF_START;
                            thaddr_d = 1'b0;
                            served_d = '0;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and request registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            fmt_q    <= F_OPT_EXT;
            sub_q    <= SF_START;
            thaddr_q <= 1'b0;
            tpend_q  <= 1'b0;
            served_q <= '0;
            pend_q   <= '0;
            lost_q   <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            fmt_q    <= fmt_d;
            sub_q    <= sub_d;
            thaddr_q <= thaddr_d;
            tpend_q  <= tpend_d;
            served_q <= served_d;
            pend_q   <= pend_d;
            lost_q   <= lost_d;
            flush_q  <= flush_d;
        end
    end

    assign valid_o            = valid_q;
    assign format_o           = fmt_q;
    assign subformat_o        = sub_q;
    assign thaddr_o           = thaddr_q;
    assign branch_map_flush_o = flush_q;
    assign lost_o             = lost_q;
    assign busy_o             = (state_q != S_IDLE);

endmodule

// File: tb/tb_trdb_packet_scheduler.sv
// Directed bench for the trace packet scheduler.
module tb_trdb_packet_scheduler;
    import trdb_pkg::*;

    localparam int unsigned RCL = 16;

    logic                        clk_i = 1'b0;
    logic                        rst_i, enable_i, start_i, trap_i, thaddr_i;
    logic                        context_i, updiscon_i, bm_full_i, ready_i;
    logic [BRANCH_COUNT_LEN-1:0] branches_i;
    logic [RCL-1:0]              resync_period_i;
    logic                        valid_o, thaddr_o, branch_map_flush_o, lost_o, busy_o;
    trdb_format_e                format_o;
    trdb_f_sync_subformat_e      subformat_o;

    int n_chk = 0;
    int n_bad = 0;
    int gap;
    int nvalid;

    trdb_packet_scheduler #(
        .RESYNC_CNT_LEN (RCL)
    ) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .enable_i           (enable_i),
        .start_i            (start_i),
        .trap_i             (trap_i),
        .thaddr_i           (thaddr_i),
        .context_i          (context_i),
        .updiscon_i         (updiscon_i),
        .bm_full_i          (bm_full_i),
        .branches_i         (branches_i),
        .resync_period_i    (resync_period_i),
        .ready_i            (ready_i),
        .valid_o            (valid_o),
        .format_o           (format_o),
        .subformat_o        (subformat_o),
        .thaddr_o           (thaddr_o),
        .branch_map_flush_o (branch_map_flush_o),
        .lost_o             (lost_o),
        .busy_o             (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_req(input string tag, input int v, input int f, input int s);
        check_val({tag, "_valid"}, int'(valid_o), v);
        check_val({tag, "_fmt"}, int'(format_o), f);
        check_val({tag, "_sub"}, int'(subformat_o), s);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; enable_i = 1'b0; start_i = 1'b0; trap_i = 1'b0; thaddr_i = 1'b0;
        context_i = 1'b0; updiscon_i = 1'b0; bm_full_i = 1'b0; ready_i = 1'b1;
        branches_i = '0; resync_period_i = '0;
        tick(); tick();
        expect_req("rst", 0, 0, 0);
        check_val("rst_busy", int'(busy_o), 0);
        check_val("rst_lost", int'(lost_o), 0);
        check_val("rst_flush", int'(branch_map_flush_o), 0);
        check_val("rst_thaddr", int'(thaddr_o), 0);
        rst_i = 1'b0;
        tick();
        check_val("idle_busy", int'(busy_o), 0);

        // enable -> support packet, then start packet with flush
        enable_i = 1'b1;
        tick();
        expect_req("support", 1, int'(F_SYNC), int'(SF_SUPPORT));
        check_val("support_busy", int'(busy_o), 1);
        tick();
        check_val("run_valid", int'(valid_o), 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        expect_req("start", 1, int'(F_SYNC), int'(SF_START));
        tick();
        check_val("start_done", int'(valid_o), 0);
        check_val("start_flush", int'(branch_map_flush_o), 1);
        tick();
        check_val("start_flush_end", int'(branch_map_flush_o), 0);

        // trap held for 5 stalled cycles, updiscon twice -> one loss
        ready_i = 1'b0; trap_i = 1'b1; thaddr_i = 1'b1; branches_i = 5'd3;
        tick();
        trap_i = 1'b0; thaddr_i = 1'b0;
        expect_req("trap", 1, int'(F_SYNC), int'(SF_TRAP));
        check_val("trap_thaddr", int'(thaddr_o), 1);
        for (int i = 0; i < 5; i++) begin
            updiscon_i = (i == 0 || i == 2);
            tick();
            check_val($sformatf("trap_hold_sub%0d", i), int'(subformat_o), int'(SF_TRAP));
            check_val($sformatf("trap_hold_thaddr%0d", i), int'(thaddr_o), 1);
            if (i == 0) check_val("lost_after_first", int'(lost_o), 0);
        end
        updiscon_i = 1'b0;
        check_val("lost_set", int'(lost_o), 1);
        ready_i = 1'b1;
        tick();
        expect_req("dd_after_trap", 1, int'(F_DIFF_DELTA), 0);
        check_val("trap_flush", int'(branch_map_flush_o), 1);
        tick();
        check_val("dd_done", int'(valid_o), 0);
        check_val("dd_flush", int'(branch_map_flush_o), 1);
        tick();

        // start and trap together -> back-to-back
        start_i = 1'b1; trap_i = 1'b1;
        tick();
        start_i = 1'b0; trap_i = 1'b0;
        expect_req("b2b_start", 1, int'(F_SYNC), int'(SF_START));
        tick();
        expect_req("b2b_trap", 1, int'(F_SYNC), int'(SF_TRAP));
        check_val("b2b_thaddr", int'(thaddr_o), 0);
        tick();
        check_val("b2b_done", int'(valid_o), 0);
        tick();

        // updiscon with empty branch map, then bm_full
        branches_i = '0; updiscon_i = 1'b1;
        tick();
        updiscon_i = 1'b0;
        expect_req("addr_only", 1, int'(F_ADDR_ONLY), 0);
        tick();
        check_val("addr_only_flush", int'(branch_map_flush_o), 0);
        bm_full_i = 1'b1;
        tick();
        bm_full_i = 1'b0;
        expect_req("bmfull", 1, int'(F_DIFF_DELTA), 0);
        tick();
        check_val("bmfull_flush", int'(branch_map_flush_o), 1);

        // disable with nothing outstanding
        enable_i = 1'b0;
        tick();
        check_val("disable_busy", int'(busy_o), 0);

        // periodic resync
        resync_period_i = 16'd8; enable_i = 1'b1;
        tick();
        expect_req("support2", 1, int'(F_SYNC), int'(SF_SUPPORT));
        tick();
        gap = 0;
        while (!valid_o && gap < 20) begin tick(); gap++; end
        check_val("resync_gap1", gap, 8);
        expect_req("resync", 1, int'(F_SYNC), int'(SF_START));
        tick();
        check_val("resync_flush", int'(branch_map_flush_o), 1);
        gap = 0;
        while (!valid_o && gap < 20) begin tick(); gap++; end
        check_val("resync_gap2", gap, 8);
        resync_period_i = '0;
        nvalid = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (valid_o) nvalid++;
        end
        check_val("resync_off", nvalid, 0);

        // disable while a request is stalled
        ready_i = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0; enable_i = 1'b0;
        tick();
        check_val("dis_hold_valid", int'(valid_o), 1);
        check_val("dis_hold_busy", int'(busy_o), 1);
        ready_i = 1'b1;
        tick();
        check_val("dis_done_valid", int'(valid_o), 0);
        check_val("dis_done_busy", int'(busy_o), 0);

        // reset while holding a request
        enable_i = 1'b1;
        tick(); tick();
        ready_i = 1'b0; context_i = 1'b1;
        tick();
        context_i = 1'b0;
        expect_req("context", 1, int'(F_SYNC), int'(SF_CONTEXT));
        tick();
        check_val("context_hold", int'(valid_o), 1);
        rst_i = 1'b1;
        tick();
        expect_req("hold_rst", 0, 0, 0);
        check_val("hold_rst_busy", int'(busy_o), 0);
        check_val("hold_rst_lost", int'(lost_o), 0);
        check_val("hold_rst_flush", int'(branch_map_flush_o), 0);
        rst_i = 1'b0; enable_i = 1'b0;
        tick();
        check_val("post_rst_busy", int'(busy_o), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
